// File: rtl/ft_stream_pkg.sv
// Purpose : shared types and constants for the A2F stream framing logic.
// Latency : n/a (types and helpers only).
// Backpr. : n/a.
//
// Contents: packer FSM state encoding, default sync tag, header word layout
// (tag in [31:16], sequence number in [15:0]) and a header builder.
package ft_stream_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } state_e;

  localparam logic [15:0] SYNC_TAG_DEF = 16'hA55A;

  // Header word layout: the packed struct fixes tag at [31:16], seq at [15:0].
  typedef struct packed {
    logic [15:0] tag;
    logic [15:0] seq;
  } hdr_t;

  function automatic logic [31:0] make_hdr(input logic [15:0] tag, input logic [15:0] seq);
    hdr_t h;
    h.tag = tag;
    h.seq = seq;
    return h;
  endfunction

endpackage

// File: rtl/iq_frame_packer_sat_counter.sv
// Purpose : saturating up-counter, steps by 1 or by STEP in one cycle.
// Latency : count_o reflects an increment one cycle after the request.
// Backpr. : none; sticks at all-ones once reached.
//
// Ports: clk, reset_n (async, active-low), inc_one_i (+1), inc_step_i (+STEP,
// wins over inc_one_i), count_o (registered count).
module sat_counter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc_one_i,
  input  logic             inc_step_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH:0] STEP_W = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum;

  // One guard bit catches the carry out; a carry means clamp to all-ones.
  always_comb begin
    sum = {1'b0, cnt_q};
    if (inc_step_i) begin
      sum = {1'b0, cnt_q} + STEP_W;
    end else if (inc_one_i) begin
      sum = {1'b0, cnt_q} + ONE_W;
    end
    cnt_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/iq_frame_packer.sv
// Purpose : packs 8-bit I/Q pairs two-per-word and frames them (header + FRAME_WORDS) into the A2F FIFO.
// Latency : payload write 1 cycle after the completing sample; header write 2 cycles after frame start.
// Backpr. : a full FIFO drops the rest of the frame up to the next frame boundary; samples are never stalled.
//
// Ports: clk, reset_n (async, active-low); enable (stream on/off level);
// s_valid/s_i/s_q (sample strobe and components); fifo_full (A2F full);
// fifo_wr/fifo_wdata (one-cycle write request and word); seq_num (frame
// sequence number); drop_cnt (dropped words, saturating); frame_active.
module iq_frame_packer
  import ft_stream_pkg::*;
#(
  parameter int          SAMPLE_WIDTH = 8,
  parameter int          FRAME_WORDS  = 1024,
  parameter logic [15:0] SYNC_TAG     = SYNC_TAG_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    s_valid,
  input  logic [SAMPLE_WIDTH-1:0] s_i,
  input  logic [SAMPLE_WIDTH-1:0] s_q,
  input  logic                    fifo_full,
  output logic                    fifo_wr,
  output logic [31:0]             fifo_wdata,
  output logic [15:0]             seq_num,
  output logic [15:0]             drop_cnt,
  output logic                    frame_active
);

  localparam int             CNT_W  = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] FW_CNT = CNT_W'(FRAME_WORDS);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic               half_q, half_d;       // low half-word captured, waiting for the high one
  logic [15:0]        low_q, low_d;
  logic [15:0]        seq_q, seq_d;
  logic               charged_q, charged_d; // frame already billed in full at HEADER
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               active_q, active_d;

  logic               abort;
  logic               word_done;
  logic [CNT_W-1:0]   cnt_next;
  logic               boundary;
  logic               drop_one;
  logic               drop_frame;

  // Enable low outranks everything else, including a completing sample.
  assign abort     = (state_q != IDLE) && !enable;
  // half_q is always clear in HEADER, so a word can only complete in PAYLOAD/DROP.
  assign word_done = (state_q != IDLE) && s_valid && half_q;
  assign cnt_next  = word_cnt_q + 1'b1;
  assign boundary  = word_done && (cnt_next == FW_CNT);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (enable) state_d = HEADER;
        HEADER:  state_d = fifo_full ? DROP : PAYLOAD;
        PAYLOAD: begin
          if (boundary)                    state_d = HEADER;
          else if (word_done && fifo_full) state_d = DROP;
        end
        DROP:    if (boundary) state_d = HEADER;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output / datapath logic
  always_comb begin
    half_d     = half_q;
    low_d      = low_q;
    word_cnt_d = word_cnt_q;
    seq_d      = seq_q;
    charged_d  = charged_q;
    wr_d       = 1'b0;
    wdata_d    = wdata_q;
    drop_one   = 1'b0;
    drop_frame = 1'b0;

    if (abort) begin
      // Partial half-word is thrown away; the seq bump marks the gap to the host.
      half_d     = 1'b0;
      word_cnt_d = '0;
      seq_d      = seq_q + 16'd1;
      charged_d  = 1'b0;
    end else begin
      if ((state_q != IDLE) && s_valid) begin
        if (!half_q) begin
          low_d  = {s_q, s_i};
          half_d = 1'b1;
        end else begin
          half_d = 1'b0;
        end
      end

      case (state_q)
        HEADER: begin
          if (!fifo_full) begin
            wr_d      = 1'b1;
            wdata_d   = make_hdr(SYNC_TAG, seq_q);
            charged_d = 1'b0;
          end else begin
            drop_frame = 1'b1;
            charged_d  = 1'b1;
          end
        end
        PAYLOAD: begin
          if (word_done) begin
            if (!fifo_full) begin
              wr_d    = 1'b1;
              wdata_d = {s_q, s_i, low_q};
            end else begin
              drop_one = 1'b1;
            end
          end
        end
        DROP: begin
          if (word_done && !charged_q) drop_one = 1'b1;
        end
        default: ;
      endcase

      if (word_done) begin
        word_cnt_d = boundary ? '0 : cnt_next;
        if (boundary) seq_d = seq_q + 16'd1;
      end
    end

    active_d = (state_d == HEADER) || (state_d == PAYLOAD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_cnt_q <= '0;
      half_q     <= 1'b0;
      low_q      <= '0;
      seq_q      <= '0;
      charged_q  <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      active_q   <= 1'b0;
    end else begin
      word_cnt_q <= word_cnt_d;
      half_q     <= half_d;
      low_q      <= low_d;
      seq_q      <= seq_d;
      charged_q  <= charged_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      active_q   <= active_d;
    end
  end

  sat_counter #(
    .WIDTH (16),
    .STEP  (FRAME_WORDS)
  ) u_drop (
    .clk        (clk),
    .reset_n    (reset_n),
    .inc_one_i  (drop_one),
    .inc_step_i (drop_frame),
    .count_o    (drop_cnt)
  );

  assign fifo_wr      = wr_q;
  assign fifo_wdata   = wdata_q;
  assign seq_num      = seq_q;
  assign frame_active = active_q;

endmodule
